// File: rtl/rv_mem_pkg.sv
// Purpose : shared types and constants for the memory-stage load/store engine.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state type, funct3 codes, access-size helper, default timeout.
package rv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } mau_state_t;

   // Access size decoded from funct3; unknown codes are treated as words.
   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } acc_size_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int TIMEOUT_CYC_DEFAULT = 64;

   function automatic acc_size_t f3_size(input logic [2:0] f3);
      acc_size_t sz;
      case (f3)
         F3_B, F3_BU: sz = SZ_B;
         F3_H, F3_HU: sz = SZ_H;
         default:     sz = SZ_W;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Purpose : byte-enable generation, store-lane shifting and load extract/extend.
// Latency : purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
//
// Ports: funct3/offset select size and byte lane; wdata -> be + wdata_lane for
// stores; rdata -> load_ext for loads. Misaligned offset bits are dropped
// (H ignores offset[0], W ignores offset[1:0]).
module mau_lane_align
   import rv_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] load_ext
);

   acc_size_t   sz;
   logic [1:0]  lane;
   logic [4:0]  shamt;
   logic        zext;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign sz   = f3_size(funct3);
   assign zext = funct3[2];

   always_comb begin
      lane = 2'b00;
      case (sz)
         SZ_B:    lane = offset;
         SZ_H:    lane = {offset[1], 1'b0};
         default: lane = 2'b00;
      endcase
   end

   assign shamt   = {lane, 3'b000};
   assign rd_byte = rdata[shamt +: 8];
   // lane[0] is 0 for halves, so shamt is 0 or 16 here.
   assign rd_half = rdata[shamt +: 16];

   always_comb begin
      be         = 4'b1111;
      wdata_lane = wdata;
      load_ext   = rdata;
      case (sz)
         SZ_B: begin
            be         = 4'b0001 << lane;
            wdata_lane = {24'h0, wdata[7:0]} << shamt;
            load_ext   = {{24{~zext & rd_byte[7]}}, rd_byte};
         end
         SZ_H: begin
            be         = 4'b0011 << lane;
            wdata_lane = {16'h0, wdata[15:0]} << shamt;
            load_ext   = {{16{~zext & rd_half[15]}}, rd_half};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose : MEM-stage load/store engine driving a req/gnt/rvalid data bus.
// Latency : min 2 cycles from op seen in IDLE to DONE (grant+data in first REQ).
// Backpressure: stall held while waiting on bus_gnt/bus_rvalid; TIMEOUT_CYC abort.
//
// Ports: pipeline side MemRead/MemWrite/funct3/addr/wdata in, stall/load_data/
// mem_err out; bus side bus_req/we/addr/be/wdata out, bus_gnt/rvalid/rdata in.
// Build option: MAU_MISALIGN_TRAP_EN traps misaligned H/W accesses without
// touching the bus; otherwise misaligned offset bits are simply dropped.
module mem_access_unit
   import rv_mem_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        mem_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   mau_state_t  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] load_data_q, load_data_d;
   logic        mem_err_q, mem_err_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;

   logic [2:0]  alg_f3;
   logic [1:0]  alg_off;
   logic [3:0]  alg_be;
   logic [31:0] alg_wdata;
   logic [31:0] alg_load;
   logic        mem_op;
   logic        misalign;

   assign mem_op = MemRead | MemWrite;

`ifdef MAU_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      case (f3_size(funct3))
         SZ_B:    misalign = 1'b0;
         SZ_H:    misalign = addr[0];
         default: misalign = |addr[1:0];
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   // One aligner serves both paths: live inputs while latching a store in
   // IDLE, latched size/offset while a load's data is on the bus.
   assign alg_f3  = (state_q == IDLE) ? funct3    : f3_q;
   assign alg_off = (state_q == IDLE) ? addr[1:0] : off_q;

   mau_lane_align u_align (
      .funct3     (alg_f3),
      .offset     (alg_off),
      .wdata      (wdata),
      .rdata      (bus_rdata),
      .be         (alg_be),
      .wdata_lane (alg_wdata),
      .load_ext   (alg_load)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      load_data_d = load_data_q;
      mem_err_d   = 1'b0;
      f3_d        = f3_q;
      off_d       = off_q;
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (mem_op) begin
               if (misalign) begin
                  state_d   = DONE;
                  mem_err_d = 1'b1;
               end else begin
                  state_d     = REQ;
                  bus_req_d   = 1'b1;
                  // Read wins when both MemRead and MemWrite are set.
                  bus_we_d    = MemWrite & ~MemRead;
                  bus_addr_d  = {addr[31:2], 2'b00};
                  bus_be_d    = alg_be;
                  bus_wdata_d = alg_wdata;
                  f3_d        = funct3;
                  off_d       = addr[1:0];
               end
            end
         end
         REQ: begin
            cnt_d = cnt_q + 8'd1;
            if (bus_gnt) begin
               bus_req_d = 1'b0;
               if (bus_we_q) begin
                  state_d = DONE;
               end else if (bus_rvalid) begin
                  load_data_d = alg_load;
                  state_d     = DONE;
               end else begin
                  state_d = WAIT_R;
               end
            end else if (cnt_q == TO_LAST) begin
               bus_req_d = 1'b0;
               mem_err_d = 1'b1;
               state_d   = DONE;
            end
         end
         WAIT_R: begin
            cnt_d = cnt_q + 8'd1;
            if (bus_rvalid) begin
               load_data_d = alg_load;
               state_d     = DONE;
            end else if (cnt_q == TO_LAST) begin
               mem_err_d = 1'b1;
               state_d   = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'h0;
         bus_be_q    <= 4'h0;
         bus_wdata_q <= 32'h0;
         load_data_q <= 32'h0;
         mem_err_q   <= 1'b0;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         load_data_q <= load_data_d;
         mem_err_q   <= mem_err_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
      end
   end

   // Gated by rst_n so the pipeline is never frozen while held in reset.
   assign stall = rst_n & (((state_q == IDLE) & mem_op) |
                           (state_q == REQ) | (state_q == WAIT_R));

   assign load_data = load_data_q;
   assign mem_err   = mem_err_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose : directed self-checking bench for mem_access_unit.
// Latency : n/a.
// Backpressure: bench drives bus_gnt/bus_rvalid with per-op delays.
module tb_mem_access_unit;
   import rv_mem_pkg::*;

   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic        stall, mem_err, bus_req, bus_we;
   logic [31:0] load_data, bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = 32'h0;

   mem_access_unit #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
      .load_data(load_data), .mem_err(mem_err), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_fail = 0;

   // Expected per-cycle outputs, maintained by the transaction driver.
   logic        chk_en = 1'b0;
   logic        exp_stall = 1'b0, exp_req = 1'b0, exp_err = 1'b0, exp_we = 1'b0;
   logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0, model_load = 32'h0;
   logic [3:0]  exp_be = 4'h0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---- reference rules, in plain arithmetic ----
   function automatic int ref_size(input logic [2:0] f3);
      if (f3[1:0] == 2'd0) return 1;
      if (f3[1:0] == 2'd1) return 2;
      return 4;
   endfunction

   function automatic int ref_lane(input logic [31:0] a, input int sz);
      return (int'(a[1:0]) / sz) * sz;
   endfunction

   function automatic logic [31:0] ref_mask(input int sz);
      logic [63:0] m;
      m = (64'd1 << (sz * 8)) - 64'd1;
      return m[31:0];
   endfunction

   function automatic logic [3:0] ref_be(input int sz, input int ln);
      logic [7:0] b;
      b = ((8'd1 << sz) - 8'd1) << ln;
      return b[3:0];
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] rd,
                                            input int sz, input int ln);
      logic [31:0] v, m;
      m = ref_mask(sz);
      v = (rd >> (ln * 8)) & m;
      if (!f3[2] && sz < 4 && v[sz*8-1]) v = v | ~m;
      return v;
   endfunction

   function automatic logic ref_trap(input logic [31:0] a, input int sz);
`ifdef MAU_MISALIGN_TRAP_EN
      return (int'(a[1:0]) % sz) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // ---- single compare process ----
   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", {31'h0, stall}, {31'h0, exp_stall});
         check("bus_req", {31'h0, bus_req}, {31'h0, exp_req});
         check("mem_err", {31'h0, mem_err}, {31'h0, exp_err});
         check("load_data", load_data, model_load);
         if (exp_req) begin
            check("bus_addr", bus_addr, exp_addr);
            check("bus_be", {28'h0, bus_be}, {28'h0, exp_be});
            check("bus_we", {31'h0, bus_we}, {31'h0, exp_we});
            if (exp_we) check("bus_wdata", bus_wdata, exp_wdata);
         end
      end
   end

   // gnt_dly: REQ cycles before the grant; rv_dly: cycles after the grant cycle
   // until rvalid (0 = same cycle).
   task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input int gnt_dly, input int rv_dly,
                         output int stalls, output int errs);
      int sz, ln, t, w;
      logic trap, timed_out, granted, done;
      sz = ref_size(f3);
      ln = ref_lane(a, sz);
      trap = ref_trap(a, sz);
      stalls = 0; errs = 0; timed_out = 1'b0;
      exp_addr  = {a[31:2], 2'b00};
      exp_be    = ref_be(sz, ln);
      exp_we    = wr & ~rd;
      exp_wdata = (wd & ref_mask(sz)) << (ln * 8);
      // IDLE cycle
      @(posedge clk); #1;
      MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = wd;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = rdat;
      exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0; chk_en = 1'b1;
      @(negedge clk); if (stall) stalls++; if (mem_err) errs++;
      if (!trap) begin
         t = 0; w = 0; granted = 1'b0; done = 1'b0;
         while (!done) begin
            @(posedge clk); #1;
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            exp_stall = 1'b1; exp_err = 1'b0;
            if (!granted) begin
               exp_req = 1'b1;
               if (t == gnt_dly) begin
                  bus_gnt = 1'b1; granted = 1'b1;
                  if (!rd) done = 1'b1;
                  else if (rv_dly == 0) begin bus_rvalid = 1'b1; done = 1'b1; end
               end
            end else begin
               exp_req = 1'b0; w++;
               if (w == rv_dly) begin bus_rvalid = 1'b1; done = 1'b1; end
            end
            if (!done && t == TMO - 1) begin done = 1'b1; timed_out = 1'b1; end
            t++;
            @(negedge clk); if (stall) stalls++; if (mem_err) errs++;
         end
      end
      // DONE cycle: pipeline still presents the same op; it must be ignored.
      @(posedge clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (rd && !trap && !timed_out) model_load = ref_load(f3, rdat, sz, ln);
      exp_stall = 1'b0; exp_req = 1'b0; exp_err = trap | timed_out;
      @(negedge clk); if (stall) stalls++; if (mem_err) errs++;
      // Idle cycle with a stray rvalid that must not disturb load_data.
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
      exp_err = 1'b0; exp_stall = 1'b0;
      @(negedge clk); if (mem_err) errs++;
      bus_rvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, er;
      // Reset state, with a load request already presented.
      MemRead = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_bus_req", {31'h0, bus_req}, 32'h0);
      check("rst_bus_we", {31'h0, bus_we}, 32'h0);
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_bus_be", {28'h0, bus_be}, 32'h0);
      check("rst_bus_wdata", bus_wdata, 32'h0);
      check("rst_load", load_data, 32'h0);
      check("rst_err", {31'h0, mem_err}, 32'h0);
      MemRead = 1'b0;
      rst_n = 1'b1;

      run_op(1, 0, F3_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, st, er);
      check("lw_stalls", st, 2);
      check("lw_load", load_data, 32'hDEAD_BEEF);
      check("lw_be", {28'h0, bus_be}, 32'hF);

      run_op(1, 0, F3_B, 32'h103, 32'h0, 32'h80FF_FF12, 0, 0, st, er);
      check("lb_addr", bus_addr, 32'h100);
      check("lb_load", load_data, 32'hFFFF_FF80);
      run_op(1, 0, F3_BU, 32'h103, 32'h0, 32'h80FF_FF12, 0, 0, st, er);
      check("lbu_load", load_data, 32'h0000_0080);

      run_op(0, 1, F3_H, 32'h202, 32'h0000_ABCD, 32'h0, 2, 0, st, er);
      check("sh_addr", bus_addr, 32'h200);
      check("sh_be", {28'h0, bus_be}, 32'hC);
      check("sh_wdata", bus_wdata, 32'hABCD_0000);
      check("sh_we", {31'h0, bus_we}, 32'h1);
      check("sh_stalls", st, 4);
      check("sh_load_kept", load_data, 32'h0000_0080);

      run_op(1, 0, F3_W, 32'h104, 32'h0, 32'h0BAD_F00D, 0, 5, st, er);
      check("dly_stalls", st, 7);
      check("dly_load", load_data, 32'h0BAD_F00D);

      run_op(1, 0, F3_H, 32'h102, 32'h0, 32'h8001_7FFF, 0, 0, st, er);
      check("lh_load", load_data, 32'hFFFF_8001);
      run_op(1, 0, F3_HU, 32'h100, 32'h0, 32'h8001_7FFF, 1, 2, st, er);
      check("lhu_load", load_data, 32'h0000_7FFF);

      run_op(0, 1, F3_B, 32'h301, 32'hFFFF_FF55, 32'h0, 0, 0, st, er);
      check("sb_be", {28'h0, bus_be}, 32'h2);
      check("sb_wdata", bus_wdata, 32'h0000_5500);

      run_op(1, 1, F3_W, 32'h40, 32'h1111_1111, 32'hCAFE_F00D, 0, 0, st, er);
      check("rw_is_read", {31'h0, bus_we}, 32'h0);
      check("rw_load", load_data, 32'hCAFE_F00D);

      run_op(1, 0, F3_W, 32'h80, 32'h0, 32'h9999_9999, 1000, 0, st, er);
      check("tmo_stalls", st, TMO + 1);
      check("tmo_err_pulses", er, 1);
      check("tmo_load_kept", load_data, 32'hCAFE_F00D);

      run_op(1, 0, F3_W, 32'h101, 32'h0, 32'h1122_3344, 0, 0, st, er);
`ifdef MAU_MISALIGN_TRAP_EN
      check("mis_w_stalls", st, 1);
      check("mis_w_err", er, 1);
      check("mis_w_load", load_data, 32'hCAFE_F00D);
`else
      check("mis_w_stalls", st, 2);
      check("mis_w_err", er, 0);
      check("mis_w_load", load_data, 32'h1122_3344);
`endif
      run_op(1, 0, F3_H, 32'h103, 32'h0, 32'hBEEF_1234, 0, 0, st, er);
`ifdef MAU_MISALIGN_TRAP_EN
      check("mis_h_load", load_data, 32'hCAFE_F00D);
`else
      check("mis_h_load", load_data, 32'hFFFF_BEEF);
`endif

      // Reset while requesting: bus_req must drop without a clock edge.
      chk_en = 1'b0;
      @(posedge clk); #1;
      MemRead = 1'b1; MemWrite = 1'b0; funct3 = F3_W; addr = 32'h500;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      @(posedge clk); #2;
      check("rreq_pre", {31'h0, bus_req}, 32'h1);
      rst_n = 1'b0; #1;
      check("rreq_async", {31'h0, bus_req}, 32'h0);
      check("rreq_stall", {31'h0, stall}, 32'h0);
      MemRead = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("rreq_load", load_data, 32'h0);

      // Reset in WAIT_R followed by a late rvalid.
      @(posedge clk); #1;
      MemRead = 1'b1; addr = 32'h504;
      @(posedge clk); #1;
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      check("wr_req_low", {31'h0, bus_req}, 32'h0);
      check("wr_stall", {31'h0, stall}, 32'h1);
      rst_n = 1'b0; #1;
      check("wr_rst_stall", {31'h0, stall}, 32'h0);
      MemRead = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      @(negedge clk);
      check("late_rv_load", load_data, 32'h0);
      check("late_rv_err", {31'h0, mem_err}, 32'h0);
      check("late_rv_stall", {31'h0, stall}, 32'h0);
      check("late_rv_req", {31'h0, bus_req}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
